// File: rtl/wb_stage.sv
// Writeback stage: a capture register (S1) followed by a write register (S2).
// Load results are formatted combinationally from S1, and both stages feed the bypass network.
module wb_stage #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic             rd_we_i,
    input  logic [DEPTH-1:0] rd_addr_i,
    input  logic [1:0]       wb_sel_i,
    input  logic [WIDTH-1:0] alu_res_i,
    input  logic [WIDTH-1:0] load_data_i,
    input  logic [WIDTH-1:0] pc_plus4_i,
    input  logic [1:0]       ld_size_i,
    input  logic             ld_unsigned_i,
    input  logic [2:0]       addr_low_i,
    output logic             wr_en_o,
    output logic [DEPTH-1:0] addr_wr_o,
    output logic [WIDTH-1:0] data_wr_o,
    output logic             fwd1_valid_o,
    output logic [DEPTH-1:0] fwd1_addr_o,
    output logic [WIDTH-1:0] fwd1_data_o,
    output logic             fwd2_valid_o,
    output logic [DEPTH-1:0] fwd2_addr_o,
    output logic [WIDTH-1:0] fwd2_data_o,
    output logic [63:0]      retired_o
);

    logic             v1_q, we1_q, uns1_q;
    logic [DEPTH-1:0] addr1_q;
    logic [1:0]       sel1_q, size1_q;
    logic [WIDTH-1:0] alu1_q, ld1_q, pc1_q;
    logic [2:0]       alow1_q;

    logic             v2_q, we2_q;
    logic [DEPTH-1:0] addr2_q;
    logic [WIDTH-1:0] data2_q;
    logic [63:0]      retired_q;

    logic [WIDTH-1:0] sh_b, sh_h, sh_w, ld_ext, fmt_d;
    logic             sext;

    // S1 load condition: flush wins over everything; stall holds the contents.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v1_q    <= 1'b0;
            we1_q   <= 1'b0;
            uns1_q  <= 1'b0;
            addr1_q <= '0;
            sel1_q  <= 2'b00;
            size1_q <= 2'b00;
            alu1_q  <= '0;
            ld1_q   <= '0;
            pc1_q   <= '0;
            alow1_q <= 3'd0;
        end else if (flush_i) begin
            v1_q <= 1'b0;
        end else if (!stall_i) begin
            v1_q <= in_valid_i;
            if (in_valid_i) begin
                we1_q   <= rd_we_i;
                uns1_q  <= ld_unsigned_i;
                addr1_q <= rd_addr_i;
                sel1_q  <= wb_sel_i;
                size1_q <= ld_size_i;
                alu1_q  <= alu_res_i;
                ld1_q   <= load_data_i;
                pc1_q   <= pc_plus4_i;
                alow1_q <= addr_low_i;
            end
        end
    end

    // The shift amounts drop the offset bits that lie below the access size.
    always_comb begin
        sh_b = ld1_q >> {alow1_q, 3'b000};
        sh_h = ld1_q >> {alow1_q[2:1], 4'b0000};
        sh_w = ld1_q >> {alow1_q[2], 5'b00000};
        sext = 1'b0;
        ld_ext = ld1_q;
        case (size1_q)
            2'b00: begin
                sext   = !uns1_q && sh_b[7];
                ld_ext = {{(WIDTH-8){sext}}, sh_b[7:0]};
            end
            2'b01: begin
                sext   = !uns1_q && sh_h[15];
                ld_ext = {{(WIDTH-16){sext}}, sh_h[15:0]};
            end
            2'b10: begin
                sext   = !uns1_q && sh_w[31];
                ld_ext = {{(WIDTH-32){sext}}, sh_w[31:0]};
            end
            default: ld_ext = ld1_q;
        endcase
    end

    always_comb begin
        case (sel1_q)
            2'b00:   fmt_d = alu1_q;
            2'b01:   fmt_d = ld_ext;
            2'b10:   fmt_d = pc1_q;
            default: fmt_d = '0;
        endcase
    end

    // A stall keeps the instruction in S1, so S2 receives a bubble.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v2_q      <= 1'b0;
            we2_q     <= 1'b0;
            addr2_q   <= '0;
            data2_q   <= '0;
            retired_q <= 64'd0;
        end else begin
            v2_q    <= v1_q && !stall_i;
            we2_q   <= we1_q;
            addr2_q <= addr1_q;
            data2_q <= fmt_d;
            if (v2_q) retired_q <= retired_q + 64'd1;
        end
    end

    assign in_ready_o   = !stall_i;
    assign wr_en_o      = v2_q && we2_q && (addr2_q != '0);
    assign addr_wr_o    = addr2_q;
    assign data_wr_o    = data2_q;
    // Loads in S1 are not forwarded.
    assign fwd1_valid_o = v1_q && we1_q && (addr1_q != '0) && (sel1_q != 2'b01);
    assign fwd1_addr_o  = addr1_q;
    assign fwd1_data_o  = fmt_d;
    assign fwd2_valid_o = wr_en_o;
    assign fwd2_addr_o  = addr2_q;
    assign fwd2_data_o  = data2_q;
    assign retired_o    = retired_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: a vector table for formatting and writeback,
// followed by hand-written stall, flush and reset sequences.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, stall = 1'b0, flush = 1'b0;
    logic        rd_we = 1'b0, ld_uns = 1'b0;
    logic [4:0]  rd_addr = '0;
    logic [1:0]  wb_sel = '0, ld_size = '0;
    logic [63:0] alu = '0, ld = '0, pc4 = '0;
    logic [2:0]  alow = '0;
    logic        in_ready, wr_en, f1v, f2v;
    logic [4:0]  waddr, f1a, f2a;
    logic [63:0] wdata, f1d, f2d, retired;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    wb_stage #(.WIDTH(64), .DEPTH(5)) dut (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .stall_i(stall), .flush_i(flush), .rd_we_i(rd_we), .rd_addr_i(rd_addr),
        .wb_sel_i(wb_sel), .alu_res_i(alu), .load_data_i(ld), .pc_plus4_i(pc4),
        .ld_size_i(ld_size), .ld_unsigned_i(ld_uns), .addr_low_i(alow),
        .wr_en_o(wr_en), .addr_wr_o(waddr), .data_wr_o(wdata),
        .fwd1_valid_o(f1v), .fwd1_addr_o(f1a), .fwd1_data_o(f1d),
        .fwd2_valid_o(f2v), .fwd2_addr_o(f2a), .fwd2_data_o(f2d),
        .retired_o(retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic        we;
        logic [1:0]  sel;
        logic [63:0] alu;
        logic [63:0] ld;
        logic [63:0] pc;
        logic [1:0]  size;
        logic        uns;
        logic [2:0]  alow;
        logic        exp_wr;
        logic        exp_f1;
        logic [63:0] exp_data;
    } vec_t;

    vec_t vt[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input logic [4:0] r, input logic w, input logic [1:0] s,
                         input logic [63:0] a, input logic [63:0] l, input logic [63:0] p,
                         input logic [1:0] sz, input logic u, input logic [2:0] lo);
        in_valid = 1'b1; rd_addr = r; rd_we = w; wb_sel = s; alu = a; ld = l;
        pc4 = p; ld_size = sz; ld_uns = u; alow = lo;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    initial begin
        vt[0]  = '{5'd5, 1'b1, 2'b00, 64'h1234, 64'h0, 64'h0, 2'b00, 1'b0, 3'd0, 1'b1, 1'b1, 64'h1234};
        vt[1]  = '{5'd3, 1'b1, 2'b01, 64'h0, 64'h0000_0000_0000_F000, 64'h0, 2'b00, 1'b0, 3'd1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF0};
        vt[2]  = '{5'd3, 1'b1, 2'b01, 64'h0, 64'h0000_0000_0000_F000, 64'h0, 2'b00, 1'b1, 3'd1, 1'b1, 1'b0, 64'hF0};
        vt[3]  = '{5'd4, 1'b1, 2'b01, 64'h0, 64'h8000_0000_0000_0000, 64'h0, 2'b10, 1'b0, 3'd4, 1'b1, 1'b0, 64'hFFFF_FFFF_8000_0000};
        vt[4]  = '{5'd0, 1'b1, 2'b00, 64'hDEAD, 64'h0, 64'h0, 2'b00, 1'b0, 3'd0, 1'b0, 1'b0, 64'hDEAD};
        vt[5]  = '{5'd1, 1'b1, 2'b10, 64'h99, 64'h0, 64'h1004, 2'b00, 1'b0, 3'd0, 1'b1, 1'b1, 64'h1004};
        vt[6]  = '{5'd2, 1'b1, 2'b11, 64'h55, 64'h0, 64'h0, 2'b00, 1'b0, 3'd0, 1'b1, 1'b1, 64'h0};
        vt[7]  = '{5'd6, 1'b1, 2'b01, 64'h0, 64'h0000_8001_0000_0000, 64'h0, 2'b01, 1'b0, 3'd5, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_8001};
        vt[8]  = '{5'd7, 1'b1, 2'b01, 64'h0, 64'h0123_4567_89AB_CDEF, 64'h0, 2'b11, 1'b0, 3'd3, 1'b1, 1'b0, 64'h0123_4567_89AB_CDEF};
        vt[9]  = '{5'd8, 1'b1, 2'b01, 64'h0, 64'hFFFF_FFFF_0000_0000, 64'h0, 2'b10, 1'b1, 3'd6, 1'b1, 1'b0, 64'hFFFF_FFFF};
        vt[10] = '{5'd7, 1'b0, 2'b00, 64'h1, 64'h0, 64'h0, 2'b00, 1'b0, 3'd0, 1'b0, 1'b0, 64'h1};
        vt[11] = '{5'd9, 1'b1, 2'b01, 64'h0, 64'h7F00_0000_0000_0000, 64'h0, 2'b00, 1'b0, 3'd7, 1'b1, 1'b0, 64'h7F};

        // Reset state
        #1;
        chk("rst_wr_en", {63'd0, wr_en}, 64'd0);
        chk("rst_f1v", {63'd0, f1v}, 64'd0);
        chk("rst_f2v", {63'd0, f2v}, 64'd0);
        chk("rst_retired", retired, 64'd0);
        chk("rst_data", wdata, 64'd0);
        chk("in_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk); rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive(vt[i].rd, vt[i].we, vt[i].sel, vt[i].alu, vt[i].ld, vt[i].pc,
                  vt[i].size, vt[i].uns, vt[i].alow);
            tick();
            chk($sformatf("v%0d_f1v", i), {63'd0, f1v}, {63'd0, vt[i].exp_f1});
            if (vt[i].exp_f1) chk($sformatf("v%0d_f1d", i), f1d, vt[i].exp_data);
            chk($sformatf("v%0d_wr_pre", i), {63'd0, wr_en}, 64'd0);
            @(negedge clk); in_valid = 1'b0;
            tick();
            chk($sformatf("v%0d_wr_en", i), {63'd0, wr_en}, {63'd0, vt[i].exp_wr});
            chk($sformatf("v%0d_f2v", i), {63'd0, f2v}, {63'd0, vt[i].exp_wr});
            chk($sformatf("v%0d_addr", i), {59'd0, waddr}, {59'd0, vt[i].rd});
            chk($sformatf("v%0d_data", i), wdata, vt[i].exp_data);
            chk($sformatf("v%0d_f2d", i), f2d, vt[i].exp_data);
            chk($sformatf("v%0d_retired", i), retired, 64'(i));
        end

        // Stall for two cycles, then release
        @(negedge clk);
        drive(5'd10, 1'b1, 2'b00, 64'hAA, 64'h0, 64'h0, 2'b00, 1'b0, 3'd0);
        tick();
        chk("stall_retired", retired, 64'd12);
        @(negedge clk); in_valid = 1'b0; stall = 1'b1;
        #1 chk("stall_ready", {63'd0, in_ready}, 64'd0);
        tick();
        chk("stall1_wr_en", {63'd0, wr_en}, 64'd0);
        chk("stall1_f1v", {63'd0, f1v}, 64'd1);
        tick();
        chk("stall2_wr_en", {63'd0, wr_en}, 64'd0);
        @(negedge clk); stall = 1'b0;
        tick();
        chk("rel_wr_en", {63'd0, wr_en}, 64'd1);
        chk("rel_addr", {59'd0, waddr}, 64'd10);
        chk("rel_data", wdata, 64'hAA);

        // B presented together with a flush is never captured
        @(negedge clk);
        drive(5'd11, 1'b1, 2'b00, 64'hBB, 64'h0, 64'h0, 2'b00, 1'b0, 3'd0);
        flush = 1'b1;
        tick();
        chk("flush_f1v", {63'd0, f1v}, 64'd0);
        @(negedge clk); in_valid = 1'b0; flush = 1'b0;
        tick();
        chk("flush_wr_en", {63'd0, wr_en}, 64'd0);
        chk("flush_retired", retired, 64'd13);

        // Reset while both stages hold valid instructions
        @(negedge clk);
        drive(5'd4, 1'b1, 2'b00, 64'h77, 64'h0, 64'h0, 2'b00, 1'b0, 3'd0);
        tick();
        @(negedge clk);
        drive(5'd6, 1'b1, 2'b00, 64'h66, 64'h0, 64'h0, 2'b00, 1'b0, 3'd0);
        tick();
        chk("mid_wr_en", {63'd0, wr_en}, 64'd1);
        in_valid = 1'b0; rst_n = 1'b0;
        #1;
        chk("arst_wr_en", {63'd0, wr_en}, 64'd0);
        chk("arst_f1v", {63'd0, f1v}, 64'd0);
        chk("arst_f2v", {63'd0, f2v}, 64'd0);
        chk("arst_retired", retired, 64'd0);
        chk("arst_data", wdata, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        tick();
        chk("post_rst_wr1", {63'd0, wr_en}, 64'd0);
        tick();
        chk("post_rst_wr2", {63'd0, wr_en}, 64'd0);
        chk("post_rst_retired", retired, 64'd0);

        // First edge after reset release accepts an input
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        drive(5'd8, 1'b1, 2'b00, 64'h88, 64'h0, 64'h0, 2'b00, 1'b0, 3'd0);
        tick();
        chk("first_f1v", {63'd0, f1v}, 64'd1);
        @(negedge clk); in_valid = 1'b0;
        tick();
        chk("first_wr_en", {63'd0, wr_en}, 64'd1);
        chk("first_data", wdata, 64'h88);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
